bin_to_bcd_seq: RTL and testbench
=================================

# bin_to_bcd_seq

Sequential, parametrised binary-to-BCD converter for the frequency counter display path. It uses double dabble, processing one input bit per clock behind a start/ready/valid handshake, so the datapath is one add-3 stage per digit instead of a fully unrolled array. It adds three things: overflow detection with saturation, a leading-zero blanking mask for the 7-segment driver, and arbitrary input width and digit count. It sits between the gate-count latch and the display multiplexer.

## Interface
- BIN_W, 20: input binary width; legal range ≥ 4.
- DIGITS, 7: number of BCD digits produced; legal range ≥ 1.
- clk  in  1  single system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start_i  in  1  request a conversion; accepted only when ready_o = 1.
- bin_i  in  BIN_W  unsigned value; sampled on the accepting edge only.
- ready_o  out  1  block can accept start_i.
- valid_o  out  1  one-cycle pulse; bcd_o, blank_o and ovf_o are updated.
- bcd_o  out  4*DIGITS  result; digit d is at [4d+3:4d]; held until the next valid_o.
- blank_o  out  DIGITS  blank_o[d] = 1 when digit d and every higher digit are 0; bit 0 is always 0.
- ovf_o  out  1  last result did not fit in DIGITS digits.

## Operation
- FSM states:
  - IDLE: ready_o = 1.
    - start_i → SHIFT; latch bin_i; clear the BCD accumulator; cnt = 0.
  - SHIFT: ready_o = 0.
    - Each cycle:
      - every digit ≥ 5 gets +3;
      - then the {accumulator, operand} register shifts left by 1;
      - cnt increments.
    - When cnt = BIN_W-1 on this edge → DONE. That is the BIN_W-th shift.
  - DONE: lasts one cycle. valid_o = 1 and ready_o = 1.
    - start_i → SHIFT (back-to-back conversion).
    - Otherwise → IDLE.
- Output registers load on the SHIFT→DONE edge and on no other edge.
- Overflow:
  - A sticky flag is set whenever the bit shifted out of the top digit is 1. This is equivalent to bin_i ≥ 10^DIGITS.
  - If the flag is set, bcd_o = all 9s and ovf_o = 1.
  - Otherwise bcd_o = the accumulator and ovf_o = 0.
- blank_o is computed from the final bcd_o value. When saturated, it is all zeros.
- start_i in SHIFT is ignored and is not queued.
- bin_i changes after acceptance have no effect.
- Widths:
  - Working register is 4*DIGITS + BIN_W bits.
  - cnt is $clog2(BIN_W) bits wide, with a minimum of 1.
  - Add-3 is 4-bit modular. The ≥ 5 check guarantees no digit wraps.

## Timing
- start_i accepted at edge k → valid_o high in the cycle after edge k+BIN_W.
  - Latency is BIN_W+1 cycles from the accepting edge.
  - Throughput is one conversion per BIN_W+1 cycles with back-to-back starts.
- Reset values:
  - state IDLE, so ready_o = 1;
  - valid_o = 0, ovf_o = 0;
  - bcd_o = 0;
  - blank_o = all 1s except bit 0, i.e. display "0".
- Reset asserted mid-conversion aborts immediately, produces no valid_o, and discards the partial result.
- start_i in the same cycle that rst_n deasserts is accepted only if it is sampled at a rising edge where rst_n = 1.
- ready_o and valid_o are decoded from registered state. There is no combinational path from inputs to outputs.

## Structure
- Shared package freq_counter_pkg holds:
  - the FSM state enum (IDLE, SHIFT, DONE);
  - the BCD_DIGIT_W = 4 constant;
  - the BCD_NINE = 4'd9 constant.
- Sub-module bcd_dabble_digit: one 4-bit digit slice.
  - Input: digit.
  - Output: the digit with +3 applied when it is ≥ 5.
  - Instantiated DIGITS times with a generate loop.
- Top module contains the FSM, counter, shift register, overflow flag, and output registers with blank decode.

## Test plan
- Defaults, bin_i = 1048575 → valid_o after 21 cycles; bcd_o = 0x1048575, blank_o = 0, ovf_o = 0.
- Defaults, bin_i = 0 → bcd_o = 0x0000000, blank_o = 7'b1111110, ovf_o = 0.
- Defaults, bin_i = 999 → bcd_o = 0x0000999, blank_o = 7'b1111000.
- DIGITS = 4, bin_i = 12345 → ovf_o = 1, bcd_o = 0x9999, blank_o = 0. A following conversion of bin_i = 42 clears ovf_o and gives bcd_o = 0x0042.
- Handshake, defaults:
  - Pulse start_i mid-SHIFT with a different bin_i → ignored, and the original result is returned.
  - Hold start_i on the valid_o cycle → the next valid_o arrives exactly 21 cycles later.
- Assert rst_n = 0 at cycle 10 of a conversion → no valid_o; outputs return to reset values within the same cycle; ready_o = 1 after release.

Source files
------------

// File: rtl/freq_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : freq_counter_pkg
// Brief    : Shared types and constants for the frequency counter display path.
// Revision : 1.0 - initial release
// ============================================================================
package freq_counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_NINE    = 4'd9;

endpackage
`default_nettype wire

// File: rtl/bcd_dabble_digit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_dabble_digit
// Brief    : One double-dabble digit slice: adds 3 when the digit is >= 5.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_dabble_digit
    import freq_counter_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    // Modular add is safe: the largest input taking the +3 path is 9 -> 12.
    assign o_digit = (i_digit >= BCD_DIGIT_W'(5)) ? i_digit + BCD_DIGIT_W'(3) : i_digit;

endmodule
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_seq
// Brief    : Sequential double-dabble binary-to-BCD converter, one bit per
//            clock, with overflow saturation and leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq
    import freq_counter_pkg::*;
#(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 7
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [BIN_W-1:0]              bin_i,
    output logic                          ready_o,
    output logic                          valid_o,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_o,
    output logic [DIGITS-1:0]             blank_o,
    output logic                          ovf_o
);

    localparam int                 c_bcd_w     = BCD_DIGIT_W * DIGITS;
    localparam int                 c_work_w    = c_bcd_w + BIN_W;
    localparam int                 c_cnt_w     = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(BIN_W - 1);
    localparam logic [DIGITS-1:0]  c_blank_rst = ~DIGITS'(1);

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_work_w-1:0] r_work;
    logic                r_sticky;

    logic [c_work_w-1:0] w_adj_work;
    logic [c_work_w-1:0] w_shifted;
    logic                w_ovf_next;
    logic [c_bcd_w-1:0]  w_result;
    logic [DIGITS-1:0]   w_blank;
    logic                w_run;

    // Accumulator occupies the upper digits, operand the lower BIN_W bits.
    assign w_adj_work[BIN_W-1:0] = r_work[BIN_W-1:0];

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        bcd_dabble_digit u_digit (
            .i_digit (r_work[BIN_W + BCD_DIGIT_W*d +: BCD_DIGIT_W]),
            .o_digit (w_adj_work[BIN_W + BCD_DIGIT_W*d +: BCD_DIGIT_W])
        );
    end

    assign w_shifted  = {w_adj_work[c_work_w-2:0], 1'b0};
    assign w_ovf_next = r_sticky | w_adj_work[c_work_w-1];
    assign w_result   = w_ovf_next ? {DIGITS{BCD_NINE}} : w_shifted[c_work_w-1:BIN_W];

    // A digit blanks only if it and every digit above it are zero.
    always_comb begin
        w_blank = '0;
        w_run   = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            w_run      = w_run & (w_result[BCD_DIGIT_W*d +: BCD_DIGIT_W] == '0);
            w_blank[d] = w_run;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_work   <= '0;
            r_sticky <= 1'b0;
            ready_o  <= 1'b1;
            valid_o  <= 1'b0;
            bcd_o    <= '0;
            blank_o  <= c_blank_rst;
            ovf_o    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start_i) begin
                        r_state  <= SHIFT;
                        ready_o  <= 1'b0;
                        r_work   <= {c_bcd_w'(0), bin_i};
                        r_cnt    <= '0;
                        r_sticky <= 1'b0;
                    end else begin
                        r_state  <= IDLE;
                        ready_o  <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_work   <= w_shifted;
                    r_cnt    <= r_cnt + c_cnt_w'(1);
                    r_sticky <= w_ovf_next;
                    if (r_cnt == c_cnt_last) begin
                        r_state <= DONE;
                        ready_o <= 1'b1;
                        valid_o <= 1'b1;
                        bcd_o   <= w_result;
                        blank_o <= w_blank;
                        ovf_o   <= w_ovf_next;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_to_bcd_seq
// Brief    : Scoreboard bench for bin_to_bcd_seq (7-digit and 4-digit builds).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b;
    logic [19:0] bin_a, bin_b;
    logic        ready_a, valid_a, ovf_a;
    logic        ready_b, valid_b, ovf_b;
    logic [27:0] bcd_a;
    logic [6:0]  blank_a;
    logic [15:0] bcd_b;
    logic [3:0]  blank_b;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic [27:0] bcd;
        logic [6:0]  blank;
        logic        ovf;
        int          at;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin_to_bcd_seq #(.BIN_W(20), .DIGITS(7)) u_dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_a),
        .bin_i   (bin_a),
        .ready_o (ready_a),
        .valid_o (valid_a),
        .bcd_o   (bcd_a),
        .blank_o (blank_a),
        .ovf_o   (ovf_a)
    );

    bin_to_bcd_seq #(.BIN_W(20), .DIGITS(4)) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_b),
        .bin_i   (bin_b),
        .ready_o (ready_b),
        .valid_o (valid_b),
        .bcd_o   (bcd_b),
        .blank_o (blank_b),
        .ovf_o   (ovf_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every valid_o must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid_a === 1'b1) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e_a = q_a.pop_front();
                chk("a_bcd", {4'b0, bcd_a}, {4'b0, e_a.bcd});
                chk("a_blank", {25'b0, blank_a}, {25'b0, e_a.blank});
                chk("a_ovf", {31'b0, ovf_a}, {31'b0, e_a.ovf});
                chk("a_latency", cyc, e_a.at);
            end
        end
        if (rst_n === 1'b1 && valid_b === 1'b1) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e_b = q_b.pop_front();
                chk("b_bcd", {16'b0, bcd_b}, {4'b0, e_b.bcd});
                chk("b_blank", {28'b0, blank_b}, {25'b0, e_b.blank});
                chk("b_ovf", {31'b0, ovf_b}, {31'b0, e_b.ovf});
                chk("b_latency", cyc, e_b.at);
            end
        end
    end

    // Caller must be positioned at a falling edge.
    task automatic convert(input bit sel, input logic [19:0] v, input logic [27:0] bcd,
                           input logic [6:0] blank, input logic ovf);
        int   t = 0;
        exp_t e;
        while ((sel ? ready_b : ready_a) !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("ready_timeout", 32'd0, 32'd1);
        if (sel) begin start_b = 1'b1; bin_b = v; end
        else     begin start_a = 1'b1; bin_a = v; end
        @(posedge clk);
        #1;
        if (sel) start_b = 1'b0;
        else     start_a = 1'b0;
        e.bcd = bcd; e.blank = blank; e.ovf = ovf; e.at = cyc + 20;
        if (sel) q_b.push_back(e);
        else     q_a.push_back(e);
    endtask

    task automatic drain();
        int t = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            chk("drain_a", q_a.size(), 32'd0);
            chk("drain_b", q_b.size(), 32'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        int t;
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; bin_a = '0; bin_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready_a", {31'b0, ready_a}, 32'd1);
        chk("rst_valid_a", {31'b0, valid_a}, 32'd0);
        chk("rst_bcd_a", {4'b0, bcd_a}, 32'd0);
        chk("rst_blank_a", {25'b0, blank_a}, 32'h7E);
        chk("rst_ovf_a", {31'b0, ovf_a}, 32'd0);
        chk("rst_blank_b", {28'b0, blank_b}, 32'hE);
        rst_n = 1'b1;
        @(negedge clk);

        // Seven-digit build
        convert(1'b0, 20'd1048575, 28'h1048575, 7'b0000000, 1'b0);
        convert(1'b0, 20'd0,       28'h0000000, 7'b1111110, 1'b0);
        convert(1'b0, 20'd999,     28'h0000999, 7'b1111000, 1'b0);
        convert(1'b0, 20'd12345,   28'h0012345, 7'b1100000, 1'b0);
        convert(1'b0, 20'd1000000, 28'h1000000, 7'b0000000, 1'b0);
        drain();

        // Four-digit build: saturation and recovery
        convert(1'b1, 20'd12345,   28'h0009999, 7'b0000000, 1'b1);
        convert(1'b1, 20'd42,      28'h0000042, 7'b0001100, 1'b0);
        convert(1'b1, 20'd9999,    28'h0009999, 7'b0000000, 1'b0);
        convert(1'b1, 20'd10000,   28'h0009999, 7'b0000000, 1'b1);
        convert(1'b1, 20'd7,       28'h0000007, 7'b0001110, 1'b0);
        drain();

        // start_i during SHIFT is ignored
        convert(1'b0, 20'd271828, 28'h0271828, 7'b1000000, 1'b0);
        repeat (5) @(negedge clk);
        start_a = 1'b1; bin_a = 20'd77;
        @(negedge clk);
        start_a = 1'b0;
        drain();

        // Back-to-back: start held on the valid_o cycle
        convert(1'b0, 20'd314159, 28'h0314159, 7'b1000000, 1'b0);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (valid_a !== 1'b1 && t < 100);
        if (t >= 100) chk("b2b_valid_timeout", 32'd0, 32'd1);
        convert(1'b0, 20'd65536, 28'h0065536, 7'b1100000, 1'b0);
        drain();

        // Reset mid-conversion
        @(negedge clk);
        start_a = 1'b1; bin_a = 20'd123456;
        @(posedge clk);
        #1 start_a = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ready_a", {31'b0, ready_a}, 32'd1);
        chk("abort_valid_a", {31'b0, valid_a}, 32'd0);
        chk("abort_bcd_a", {4'b0, bcd_a}, 32'd0);
        chk("abort_blank_a", {25'b0, blank_a}, 32'h7E);
        chk("abort_ovf_a", {31'b0, ovf_a}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_ready_a", {31'b0, ready_a}, 32'd1);
        repeat (30) @(negedge clk);
        convert(1'b0, 20'd5, 28'h0000005, 7'b1111110, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
